// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch unit.
// Request is a valid/ready handshake; response is a one-cycle strobe.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetcher: next-PC select,
// imem handshake, instruction hold, sticky misalign/timeout faults.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            advance,
  pc_fetch_unit_if.master imem,
  output logic            inst_valid,
  output logic [31:0]     inst_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_fault,
  output logic            fetch_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            mis_q, mis_d;
  logic            to_q, to_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = rs1_data + imm;

  // Reserved select 11 falls back to sequential flow.
  always_comb begin
    target = pc_plus4;
    unique case (pc_sel)
      2'b01:   target = pc_q + imm;
      2'b10:   target = {jalr_sum[XLEN-1:1], 1'b0};
      default: target = pc_plus4;
    endcase
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          inst_d  = imem.imem_rsp_data;
          state_d = HOLD;
        end else if (cnt_inc == CW'(MAX_WAIT)) begin
          cnt_d   = cnt_inc;
          to_d    = 1'b1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d = target;
          if (target[1:0] == 2'b00) begin
            state_d = FETCH;
          end else begin
            mis_d   = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req_valid = (state_q == FETCH);
  assign imem.imem_addr      = pc_q;
  assign inst_valid          = (state_q == HOLD);
  assign inst_out            = inst_q;
  assign pc_out              = pc_q;
  assign misalign_fault      = mis_q;
  assign fetch_timeout       = to_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with RESET_PC=0x100, MAX_WAIT=4.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        advance;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_fault;
  logic        fetch_timeout;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit_if #(.XLEN(32)) imem ();

  pc_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0100),
    .MAX_WAIT (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_sel         (pc_sel),
    .imm            (imm),
    .rs1_data       (rs1_data),
    .advance        (advance),
    .imem           (imem.master),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .misalign_fault (misalign_fault),
    .fetch_timeout  (fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept in FETCH, respond one WAIT cycle later.
  task automatic fetch(input logic [31:0] word);
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    step();
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = word;
    step();
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
  endtask

  task automatic adv(input logic [1:0] sel, input logic [31:0] im,
                     input logic [31:0] rs1);
    pc_sel   = sel;
    imm      = im;
    rs1_data = rs1;
    advance  = 1'b1;
    step();
    advance  = 1'b0;
    pc_sel   = 2'b00;
    imm      = '0;
    rs1_data = '0;
  endtask

  initial begin
    rst_n               = 1'b0;
    pc_sel              = 2'b00;
    imm                 = '0;
    rs1_data            = '0;
    advance             = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    step();
    step();

    chk("rst_pc", pc_out, 32'h100);
    chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_misalign", 32'(misalign_fault), 32'd0);
    chk("rst_timeout", 32'(fetch_timeout), 32'd0);

    // Test 1: first fetch and sequential advance
    rst_n = 1'b1;
    step();
    chk("t1_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("t1_addr", imem.imem_addr, 32'h100);
    fetch(32'h0000_0013);
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst_out", inst_out, 32'h13);
    chk("t1_pc_out", pc_out, 32'h100);
    chk("t1_pc_plus4", pc_plus4, 32'h104);
    chk("t1_req_idle_hold", 32'(imem.imem_req_valid), 32'd0);
    adv(2'b00, 32'h0, 32'h0);
    chk("t1_next_addr", imem.imem_addr, 32'h104);
    chk("t1_next_req", 32'(imem.imem_req_valid), 32'd1);
    chk("t1_inst_cleared", 32'(inst_valid), 32'd0);

    // Test 2: branch with negative offset, reserved select
    fetch(32'h1111_1111);
    adv(2'b01, 32'hFFFF_FFF8, 32'h0);
    chk("t2_branch_addr", imem.imem_addr, 32'hFC);
    fetch(32'h2222_2222);
    adv(2'b11, 32'hDEAD_0000, 32'h5555_0000);
    chk("t2_rsvd_addr", imem.imem_addr, 32'h100);

    // Test 3: JALR LSB clear, then misaligned JALR
    fetch(32'h3333_3333);
    adv(2'b10, 32'h4, 32'h201);
    chk("t3_jalr_addr", imem.imem_addr, 32'h204);
    chk("t3_no_fault", 32'(misalign_fault), 32'd0);
    fetch(32'h4444_4444);
    adv(2'b10, 32'h2, 32'h200);
    chk("t3_misalign", 32'(misalign_fault), 32'd1);
    chk("t3_fault_pc", pc_out, 32'h202);
    chk("t3_fault_req", 32'(imem.imem_req_valid), 32'd0);
    step();
    step();
    chk("t3_fault_req_later", 32'(imem.imem_req_valid), 32'd0);
    chk("t3_fault_inst_valid", 32'(inst_valid), 32'd0);

    // Test 4: backpressure, response in accept cycle ignored
    rst_n = 1'b0;
    #1;
    chk("t4_rst_misalign", 32'(misalign_fault), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_valid", 32'(imem.imem_req_valid), 32'd1);
      chk("t4_stall_addr", imem.imem_addr, 32'h100);
      step();
    end
    chk("t4_stall_valid4", 32'(imem.imem_req_valid), 32'd1);
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    chk("t4_accepted", 32'(imem.imem_req_valid), 32'd0);
    step();
    chk("t4_early_rsp_ignored", 32'(inst_valid), 32'd0);

    // Test 5: timeout after 4 WAIT cycles (one already elapsed)
    step();
    step();
    chk("t5_no_timeout_yet", 32'(fetch_timeout), 32'd0);
    step();
    chk("t5_timeout", 32'(fetch_timeout), 32'd1);
    chk("t5_timeout_req", 32'(imem.imem_req_valid), 32'd0);
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'h5555_5555;
    advance             = 1'b1;
    pc_sel              = 2'b01;
    imm                 = 32'h40;
    step();
    step();
    imem.imem_rsp_valid = 1'b0;
    advance             = 1'b0;
    pc_sel              = 2'b00;
    imm                 = '0;
    chk("t5_pc_unchanged", pc_out, 32'h100);
    chk("t5_inst_valid", 32'(inst_valid), 32'd0);
    chk("t5_timeout_sticky", 32'(fetch_timeout), 32'd1);
    chk("t5_inst_out", inst_out, 32'd0);

    // Test 6: PC wrap, async reset in WAIT
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fetch(32'h6666_6666);
    adv(2'b10, 32'h0, 32'hFFFF_FFFC);
    chk("t6_top_addr", imem.imem_addr, 32'hFFFF_FFFC);
    chk("t6_top_plus4", pc_plus4, 32'h0);
    fetch(32'h7777_7777);
    adv(2'b00, 32'h0, 32'h0);
    chk("t6_wrap_addr", imem.imem_addr, 32'h0);
    chk("t6_wrap_req", 32'(imem.imem_req_valid), 32'd1);
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pc", pc_out, 32'h100);
    chk("t6_async_req", 32'(imem.imem_req_valid), 32'd0);
    chk("t6_async_inst_out", inst_out, 32'd0);
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'h9999_9999;
    step();
    rst_n = 1'b1;
    step();
    imem.imem_rsp_valid = 1'b0;
    chk("t6_restart_req", 32'(imem.imem_req_valid), 32'd1);
    chk("t6_restart_addr", imem.imem_addr, 32'h100);
    chk("t6_late_rsp_ignored", 32'(inst_valid), 32'd0);
    step();
    chk("t6_late_inst_out", inst_out, 32'd0);
    chk("t6_still_fetch", 32'(imem.imem_req_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
